// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank initiator: FSM state encoding,
// command direction constants and the address-width helper.
package reg_bank_pkg;

    // Controller states; VERIFY is only reachable when readback checking is built in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        VERIFY = 2'd2,
        RESP   = 2'd3
    } state_t;

    // cmd_wr encoding
    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    // Address width for a bank of nregs registers; never narrower than one bit.
    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_master_rdata_or_reduce.sv
// Combines the read buses of every bank register into one word.
// Unselected registers drive zero, so a plain bitwise OR yields the
// selected register's data (or zero when nothing is selected).
module rdata_or_reduce #(
    parameter int WIDTH = 32,
    parameter int NREGS = 4
) (
    input  logic [NREGS*WIDTH-1:0] bus,
    output logic [WIDTH-1:0]       rdata
);

    // OR together all NREGS slices of the concatenated bus
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NREGS; i++) begin
            rdata = rdata | bus[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/reg_bank_master.sv
// Initiator for a bank of wr/sel strobe registers.
// Accepts one read/write command at a time over a valid/ready port, strobes
// the addressed register for a single ACCESS cycle and returns one response.
// Optional feature: define REG_BANK_READBACK_EN to re-read every valid write
// in an extra VERIFY cycle and flag a mismatch through rsp_err.
module reg_bank_master
    import reg_bank_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 4,
    parameter int ADDR_W = addr_width(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [WIDTH-1:0]        cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_rdata,
    output logic                    rsp_err,
    output logic                    reg_wr,
    output logic [NREGS-1:0]        reg_sel,
    output logic [WIDTH-1:0]        reg_wdata,
    input  logic [NREGS*WIDTH-1:0]  reg_rdata_bus
);

    state_t              state_reg;
    state_t              state_next;

    // Latched command and response holding registers
    logic                wr_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [WIDTH-1:0]    wdata_reg;
    logic [WIDTH-1:0]    rdata_reg;
    logic                err_reg;

    logic                addr_valid;
    logic [NREGS-1:0]    sel_onehot;
    logic [WIDTH-1:0]    bank_rdata;

    // Addresses at or beyond NREGS never reach the bank
    assign addr_valid = ({1'b0, addr_reg} < (ADDR_W+1)'(NREGS));

    // One-hot decode of the latched address, gated by range check
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_sel
            assign sel_onehot[gi] = addr_valid && (addr_reg == ADDR_W'(gi));
        end
    endgenerate

    rdata_or_reduce #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_or_reduce (
        .bus   (reg_rdata_bus),
        .rdata (bank_rdata)
    );

    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and bank/handshake outputs; bank lines idle at zero
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        reg_sel    = '0;
        reg_wr     = 1'b0;
        reg_wdata  = '0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (addr_valid) begin
                    reg_sel   = sel_onehot;
                    reg_wr    = (wr_reg == CMD_WR);
                    reg_wdata = wdata_reg;
                end
`ifdef REG_BANK_READBACK_EN
                if (addr_valid && (wr_reg == CMD_WR)) begin
                    state_next = VERIFY;
                end else begin
                    state_next = RESP;
                end
`else
                state_next = RESP;
`endif
            end
`ifdef REG_BANK_READBACK_EN
            VERIFY: begin
                // Same select with the strobe low: the register presents its new value
                reg_sel    = sel_onehot;
                reg_wdata  = wdata_reg;
                state_next = RESP;
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command latch and response data/error capture
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_reg    <= CMD_RD;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        wr_reg    <= cmd_wr;
                        addr_reg  <= cmd_addr;
                        wdata_reg <= cmd_wdata;
                        rdata_reg <= '0;
                        err_reg   <= 1'b0;
                    end
                end
                ACCESS: begin
                    err_reg <= !addr_valid;
                    if (addr_valid && (wr_reg == CMD_RD)) begin
                        rdata_reg <= bank_rdata;
                    end else begin
                        rdata_reg <= '0;
                    end
                end
`ifdef REG_BANK_READBACK_EN
                VERIFY: begin
                    if (bank_rdata != wdata_reg) begin
                        err_reg   <= 1'b1;
                        rdata_reg <= bank_rdata;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_master.sv
// Self-checking bench for reg_bank_master. Two instances: "a" with four
// registers and "b" with three (so address 3 is out of range). Each has a
// behavioural register bank attached. Build with REG_BANK_READBACK_EN defined
// to exercise the write-verify path.
module tb_reg_bank_master;

`ifdef REG_BANK_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         cmd_wr;
    logic [1:0]   cmd_addr;
    logic [31:0]  cmd_wdata;
    logic         rsp_ready;

    logic         a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_err, a_reg_wr;
    logic [31:0]  a_rsp_rdata, a_reg_wdata;
    logic [3:0]   a_reg_sel;
    logic [127:0] a_bus;

    logic         b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_err, b_reg_wr;
    logic [31:0]  b_rsp_rdata, b_reg_wdata;
    logic [2:0]   b_reg_sel;
    logic [95:0]  b_bus;

    logic [31:0]  a_bank [4];
    logic [31:0]  b_bank [3];
    logic         a_stuck0;

    // Reference model: expected register contents per instance
    logic [31:0]  exp_mem [2][4];

    int total;
    int bad;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wr_cycles;
        logic [3:0]  acc_sel;
        logic [31:0] wr_data;
        logic [3:0]  resp_sel;
        logic        ready_after;
        logic        valid_after;
        logic        timeout;
    } obs_t;

    // Observation mux for the instance currently driven
    logic         use_b_sel;
    logic         s_cmd_ready, s_rsp_valid, s_rsp_err, s_reg_wr;
    logic [31:0]  s_rsp_rdata, s_reg_wdata;
    logic [3:0]   s_reg_sel;
    assign s_cmd_ready = use_b_sel ? b_cmd_ready : a_cmd_ready;
    assign s_rsp_valid = use_b_sel ? b_rsp_valid : a_rsp_valid;
    assign s_rsp_err   = use_b_sel ? b_rsp_err   : a_rsp_err;
    assign s_rsp_rdata = use_b_sel ? b_rsp_rdata : a_rsp_rdata;
    assign s_reg_wr    = use_b_sel ? b_reg_wr    : a_reg_wr;
    assign s_reg_wdata = use_b_sel ? b_reg_wdata : a_reg_wdata;
    assign s_reg_sel   = use_b_sel ? {1'b0, b_reg_sel} : a_reg_sel;

    reg_bank_master #(.WIDTH(32), .NREGS(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .reg_wr(a_reg_wr), .reg_sel(a_reg_sel), .reg_wdata(a_reg_wdata),
        .reg_rdata_bus(a_bus)
    );

    reg_bank_master #(.WIDTH(32), .NREGS(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .reg_wr(b_reg_wr), .reg_sel(b_reg_sel), .reg_wdata(b_reg_wdata),
        .reg_rdata_bus(b_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register banks: load on sel&wr, shared reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) a_bank[i] <= 32'h0;
            for (int i = 0; i < 3; i++) b_bank[i] <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++) if (a_reg_sel[i] && a_reg_wr) a_bank[i] <= a_reg_wdata;
            for (int i = 0; i < 3; i++) if (b_reg_sel[i] && b_reg_wr) b_bank[i] <= b_reg_wdata;
        end
    end

    // Bank read buses: data only when selected and not writing
    always_comb begin
        a_bus = '0;
        b_bus = '0;
        for (int i = 0; i < 4; i++)
            if (a_reg_sel[i] && !a_reg_wr && !(i == 0 && a_stuck0)) a_bus[i*32 +: 32] = a_bank[i];
        for (int i = 0; i < 3; i++)
            if (b_reg_sel[i] && !b_reg_wr) b_bus[i*32 +: 32] = b_bank[i];
    end

    function automatic int exp_lat(input bit wr, input bit valid);
        return (READBACK && wr && valid) ? 3 : 2;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) exp_mem[k][i] = 32'h0;
    endtask

    // Drive one command with rsp_ready high and record what the DUT did
    task automatic do_cmd(input bit use_b, input bit wr, input logic [1:0] addr,
                          input logic [31:0] data, output obs_t o);
        int n;
        o = '{rdata: 32'h0, err: 1'b0, lat: 0, wr_cycles: 0, acc_sel: 4'h0, wr_data: 32'h0,
              resp_sel: 4'h0, ready_after: 1'b0, valid_after: 1'b0, timeout: 1'b0};
        @(negedge clk);
        use_b_sel = use_b;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        rsp_ready = 1'b1;
        if (use_b) b_cmd_valid = 1'b1; else a_cmd_valid = 1'b1;
        n = 0;
        while (!s_cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!s_cmd_ready) o.timeout = 1'b1;
        @(negedge clk);
        a_cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
        o.lat = 1;
        while (!s_rsp_valid && o.lat < 20) begin
            if (o.lat == 1) o.acc_sel = s_reg_sel;
            if (s_reg_wr) begin o.wr_cycles++; o.wr_data = s_reg_wdata; end
            @(negedge clk);
            o.lat++;
        end
        if (!s_rsp_valid) o.timeout = 1'b1;
        if (s_reg_wr) o.wr_cycles++;
        o.rdata    = s_rsp_rdata;
        o.err      = s_rsp_err;
        o.resp_sel = s_reg_sel;
        @(negedge clk);
        o.ready_after = s_cmd_ready;
        o.valid_after = s_rsp_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_model();
        total++; if (a_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", a_cmd_ready); end
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", a_rsp_valid); end
        total++; if (a_rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", a_rsp_rdata); end
        total++; if (a_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", a_rsp_err); end
        total++; if ({a_reg_wr, a_reg_sel, a_reg_wdata} !== 37'h0) begin bad++; $display("FAIL reset_bank_lines got wr=%b sel=%b wdata=%h want all 0", a_reg_wr, a_reg_sel, a_reg_wdata); end
        total++; if (b_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_b_cmd_ready got=%b want=1", b_cmd_ready); end
        $display("reset: cmd_ready=%b rsp_valid=%b", a_cmd_ready, a_rsp_valid);
    endtask

    task automatic test_basic();
        obs_t o;
        do_cmd(1'b0, 1'b1, 2'd2, 32'hDEADBEEF, o);
        exp_mem[0][2] = 32'hDEADBEEF;
        $display("write a[2]=deadbeef: err=%b lat=%0d wr_cycles=%0d sel=%b", o.err, o.lat, o.wr_cycles, o.acc_sel);
        total++; if (o.timeout !== 1'b0) begin bad++; $display("FAIL basic_wr_timeout got=%b want=0", o.timeout); end
        total++; if (o.err !== 1'b0) begin bad++; $display("FAIL basic_wr_err got=%b want=0", o.err); end
        total++; if (o.wr_cycles != 1) begin bad++; $display("FAIL basic_wr_strobe_cycles got=%0d want=1", o.wr_cycles); end
        total++; if (o.acc_sel !== 4'b0100) begin bad++; $display("FAIL basic_wr_sel got=%b want=0100", o.acc_sel); end
        total++; if (o.wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_wr_wdata got=%h want=deadbeef", o.wr_data); end
        total++; if (o.lat != exp_lat(1'b1, 1'b1)) begin bad++; $display("FAIL basic_wr_latency got=%0d want=%0d", o.lat, exp_lat(1'b1, 1'b1)); end
        total++; if (o.ready_after !== 1'b1 || o.valid_after !== 1'b0) begin bad++; $display("FAIL basic_wr_release got ready=%b valid=%b want ready=1 valid=0", o.ready_after, o.valid_after); end
        do_cmd(1'b0, 1'b0, 2'd2, 32'h0, o);
        $display("read a[2]: rdata=%h err=%b lat=%0d", o.rdata, o.err, o.lat);
        total++; if (o.rdata !== exp_mem[0][2]) begin bad++; $display("FAIL basic_rd_data got=%h want=%h", o.rdata, exp_mem[0][2]); end
        total++; if (o.lat != 2) begin bad++; $display("FAIL basic_rd_latency got=%0d want=2", o.lat); end
        total++; if (o.wr_cycles != 0) begin bad++; $display("FAIL basic_rd_no_strobe got=%0d want=0", o.wr_cycles); end
    endtask

    task automatic test_fill();
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            do_cmd(1'b0, 1'b1, 2'(i), 32'(8'h11 * (i + 1)), o);
            exp_mem[0][i] = 32'(8'h11 * (i + 1));
            $display("write a[%0d]=%h: err=%b", i, 8'h11 * (i + 1), o.err);
        end
        for (int i = 0; i < 4; i++) begin
            do_cmd(1'b0, 1'b0, 2'(i), 32'h0, o);
            $display("read a[%0d]: rdata=%h sel=%b", i, o.rdata, o.acc_sel);
            total++; if (o.rdata !== exp_mem[0][i]) begin bad++; $display("FAIL fill_rd_data addr=%0d got=%h want=%h", i, o.rdata, exp_mem[0][i]); end
            total++; if (o.acc_sel !== 4'(1 << i)) begin bad++; $display("FAIL fill_access_sel addr=%0d got=%b want=%b", i, o.acc_sel, 4'(1 << i)); end
            total++; if (o.resp_sel !== 4'h0) begin bad++; $display("FAIL fill_resp_sel addr=%0d got=%b want=0000", i, o.resp_sel); end
        end
    endtask

    task automatic test_bad_addr();
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            exp_mem[1][i] = $urandom;
            do_cmd(1'b1, 1'b1, 2'(i), exp_mem[1][i], o);
        end
        do_cmd(1'b1, 1'b0, 2'd3, 32'h0, o);
        $display("read b[3]: rdata=%h err=%b sel=%b", o.rdata, o.err, o.acc_sel);
        total++; if (o.err !== 1'b1) begin bad++; $display("FAIL bad_rd_err got=%b want=1", o.err); end
        total++; if (o.rdata !== 32'h0) begin bad++; $display("FAIL bad_rd_rdata got=%h want=0", o.rdata); end
        total++; if (o.acc_sel !== 4'h0) begin bad++; $display("FAIL bad_rd_sel got=%b want=000", o.acc_sel); end
        do_cmd(1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, o);
        $display("write b[3]: err=%b wr_cycles=%0d", o.err, o.wr_cycles);
        total++; if (o.err !== 1'b1) begin bad++; $display("FAIL bad_wr_err got=%b want=1", o.err); end
        total++; if (o.wr_cycles != 0) begin bad++; $display("FAIL bad_wr_strobe got=%0d want=0", o.wr_cycles); end
        total++; if (o.lat != 2) begin bad++; $display("FAIL bad_wr_latency got=%0d want=2", o.lat); end
        for (int i = 0; i < 3; i++) begin
            total++; if (b_bank[i] !== exp_mem[1][i]) begin bad++; $display("FAIL bad_bank_untouched reg=%0d got=%h want=%h", i, b_bank[i], exp_mem[1][i]); end
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        int n;
        logic [31:0] val;
        val = $urandom;
        do_cmd(1'b0, 1'b1, 2'd1, val, o);
        exp_mem[0][1] = val;
        @(negedge clk);
        use_b_sel   = 1'b0;
        rsp_ready   = 1'b0;
        cmd_wr      = 1'b0;
        cmd_addr    = 2'd1;
        a_cmd_valid = 1'b1;
        n = 0;
        while (!a_cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        a_cmd_valid = 1'b0;
        n = 0;
        while (!a_rsp_valid && n < 20) begin @(negedge clk); n++; end
        total++; if (a_rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_arrives got=%b want=1", a_rsp_valid); end
        // Offer an extra write that must be ignored while the response waits
        cmd_wr      = 1'b1;
        cmd_addr    = 2'd0;
        cmd_wdata   = ~exp_mem[0][0];
        a_cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            $display("bp hold %0d: rsp_valid=%b rdata=%h cmd_ready=%b", k, a_rsp_valid, a_rsp_rdata, a_cmd_ready);
            total++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== val || a_rsp_err !== 1'b0) begin bad++; $display("FAIL bp_hold_stable cycle=%0d got valid=%b rdata=%h err=%b want valid=1 rdata=%h err=0", k, a_rsp_valid, a_rsp_rdata, a_rsp_err, val); end
            total++; if (a_cmd_ready !== 1'b0 || a_reg_sel !== 4'h0 || a_reg_wr !== 1'b0) begin bad++; $display("FAIL bp_hold_idle cycle=%0d got ready=%b sel=%b wr=%b want 0", k, a_cmd_ready, a_reg_sel, a_reg_wr); end
            @(negedge clk);
        end
        a_cmd_valid = 1'b0;
        rsp_ready   = 1'b1;
        @(negedge clk);
        total++; if (a_cmd_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got ready=%b valid=%b want ready=1 valid=0", a_cmd_ready, a_rsp_valid); end
        @(negedge clk);
        total++; if (a_cmd_ready !== 1'b1 || a_reg_sel !== 4'h0) begin bad++; $display("FAIL bp_extra_not_consumed got ready=%b sel=%b want ready=1 sel=0", a_cmd_ready, a_reg_sel); end
        do_cmd(1'b0, 1'b0, 2'd0, 32'h0, o);
        $display("read a[0] after bp: rdata=%h", o.rdata);
        total++; if (o.rdata !== exp_mem[0][0]) begin bad++; $display("FAIL bp_a0_unchanged got=%h want=%h", o.rdata, exp_mem[0][0]); end
    endtask

    task automatic test_reset_mid_write();
        obs_t o;
        int n;
        @(negedge clk);
        use_b_sel   = 1'b0;
        rsp_ready   = 1'b1;
        cmd_wr      = 1'b1;
        cmd_addr    = 2'd1;
        cmd_wdata   = 32'hA5;
        a_cmd_valid = 1'b1;
        n = 0;
        while (!a_cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        a_cmd_valid = 1'b0;
        total++; if (a_reg_wr !== 1'b1 || a_reg_sel !== 4'b0010) begin bad++; $display("FAIL rst_mid_in_access got wr=%b sel=%b want wr=1 sel=0010", a_reg_wr, a_reg_sel); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        $display("reset in access: cmd_ready=%b rsp_valid=%b wr=%b sel=%b", a_cmd_ready, a_rsp_valid, a_reg_wr, a_reg_sel);
        total++; if (a_cmd_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_handshake got ready=%b valid=%b want ready=1 valid=0", a_cmd_ready, a_rsp_valid); end
        total++; if ({a_reg_wr, a_reg_sel, a_reg_wdata} !== 37'h0) begin bad++; $display("FAIL rst_mid_bank_lines got wr=%b sel=%b wdata=%h want 0", a_reg_wr, a_reg_sel, a_reg_wdata); end
        total++; if (a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0) begin bad++; $display("FAIL rst_mid_rsp got rdata=%h err=%b want 0", a_rsp_rdata, a_rsp_err); end
        do_cmd(1'b0, 1'b0, 2'd1, 32'h0, o);
        $display("read a[1] after reset: rdata=%h", o.rdata);
        total++; if (o.rdata !== 32'h0) begin bad++; $display("FAIL rst_mid_no_commit got=%h want=0", o.rdata); end
    endtask

`ifdef REG_BANK_READBACK_EN
    task automatic test_readback();
        obs_t o;
        a_stuck0 = 1'b1;
        do_cmd(1'b0, 1'b1, 2'd0, 32'h5, o);
        a_stuck0 = 1'b0;
        exp_mem[0][0] = 32'h5;
        $display("verified write a[0]=5 stuck: err=%b rdata=%h lat=%0d", o.err, o.rdata, o.lat);
        total++; if (o.err !== 1'b1) begin bad++; $display("FAIL rb_err got=%b want=1", o.err); end
        total++; if (o.rdata !== 32'h0) begin bad++; $display("FAIL rb_rdata got=%h want=0", o.rdata); end
        total++; if (o.lat != 3) begin bad++; $display("FAIL rb_latency got=%0d want=3", o.lat); end
        total++; if (o.wr_cycles != 1) begin bad++; $display("FAIL rb_strobe got=%0d want=1", o.wr_cycles); end
    endtask
`endif

    task automatic test_random();
        obs_t o;
        bit          use_b, wr, valid;
        logic [1:0]  addr;
        logic [31:0] data, e_rdata;
        int          nregs;
        for (int t = 0; t < 40; t++) begin
            use_b = 1'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            addr  = 2'($urandom_range(0, 3));
            data  = $urandom;
            nregs = use_b ? 3 : 4;
            valid = (int'(addr) < nregs);
            e_rdata = (!wr && valid) ? exp_mem[use_b][addr] : 32'h0;
            do_cmd(use_b, wr, addr, data, o);
            if (wr && valid) exp_mem[use_b][addr] = data;
            $display("rand %0d: inst=%s wr=%b addr=%0d data=%h -> rdata=%h err=%b lat=%0d", t, use_b ? "b" : "a", wr, addr, data, o.rdata, o.err, o.lat);
            total++; if (o.timeout !== 1'b0) begin bad++; $display("FAIL rand_timeout t=%0d got=%b want=0", t, o.timeout); end
            total++; if (o.rdata !== e_rdata) begin bad++; $display("FAIL rand_rdata t=%0d got=%h want=%h", t, o.rdata, e_rdata); end
            total++; if (o.err !== !valid) begin bad++; $display("FAIL rand_err t=%0d got=%b want=%b", t, o.err, !valid); end
            total++; if (o.lat != exp_lat(wr, valid)) begin bad++; $display("FAIL rand_latency t=%0d got=%0d want=%0d", t, o.lat, exp_lat(wr, valid)); end
            total++; if (o.wr_cycles != ((wr && valid) ? 1 : 0)) begin bad++; $display("FAIL rand_strobe t=%0d got=%0d want=%0d", t, o.wr_cycles, (wr && valid) ? 1 : 0); end
            total++; if (o.acc_sel !== (valid ? 4'(1 << addr) : 4'h0)) begin bad++; $display("FAIL rand_sel t=%0d got=%b want=%b", t, o.acc_sel, valid ? 4'(1 << addr) : 4'h0); end
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        a_cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
        cmd_wr      = 1'b0;
        cmd_addr    = 2'd0;
        cmd_wdata   = 32'h0;
        rsp_ready   = 1'b0;
        a_stuck0    = 1'b0;
        use_b_sel   = 1'b0;
        test_reset();
        test_basic();
        test_fill();
        test_bad_addr();
        test_backpressure();
        test_reset_mid_write();
`ifdef REG_BANK_READBACK_EN
        test_readback();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_master.md
# reg_bank_master

Initiator for a bank of pipeline registers that use the wr/sel strobe protocol: a register loads `wdata` on the clock edge when `sel & wr`, and drives `rdata` combinationally when `sel & !wr` (otherwise 0). This block accepts read/write commands over a valid/ready port, drives the shared `reg_wr` and `reg_wdata` lines and a one-hot `reg_sel` bus, and OR-combines the bank's read buses. It returns one response per command over a second valid/ready port. It sits between a control/debug agent and the pipeline register bank.

## Interface
Parameters:
- `WIDTH`, 32: data width of each register.
- `NREGS`, 4: number of registers in the bank (≥1).
- `ADDR_W`, `$clog2(NREGS)` (min 1): command address width.

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_wr`, in, 1: 1 = write, 0 = read.
- `cmd_addr`, in, ADDR_W: register index.
- `cmd_wdata`, in, WIDTH: write data.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_rdata`, out, WIDTH: read data (0 for writes and errors).
- `rsp_err`, out, 1: address out of range (and readback mismatch, see Configuration).
- `reg_wr`, out, 1: shared write strobe to the bank.
- `reg_sel`, out, NREGS: one-hot select, register i on bit i.
- `reg_wdata`, out, WIDTH: shared write data.
- `reg_rdata_bus`, in, NREGS*WIDTH: concatenated register `rdata`, register i at bits [i*WIDTH +: WIDTH].

## Operation
- FSM states: IDLE, ACCESS, VERIFY (only with the macro), RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch wr/addr/wdata and go to ACCESS.
- ACCESS, one cycle:
  - Valid address: `reg_sel` = one-hot(addr), `reg_wr` = latched wr, `reg_wdata` = latched wdata.
  - Address ≥ NREGS: `reg_sel`=0, `reg_wr`=0, err flag set; no register is touched.
  - Read: capture the OR of all `reg_rdata_bus` slices into the rdata holding register at the end of the cycle.
  - Write: the addressed register loads at the closing edge of ACCESS.
  - Next state: RESP (or VERIFY, see Configuration).
- RESP:
  - `rsp_valid`=1; `rsp_rdata`/`rsp_err` are stable while `rsp_valid & !rsp_ready`.
  - On `rsp_ready`, go to IDLE.
- Outside ACCESS/VERIFY: `reg_sel`=0, `reg_wr`=0, `reg_wdata`=0. The bank therefore outputs 0 and no write can occur.
- Exactly one command is in flight; `cmd_ready`=0 in every state except IDLE.
- Read data path: bitwise OR of the NREGS slices. This is correct because unselected registers drive 0.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `reg_wr`=0, `reg_sel`=0, `reg_wdata`=0.
- Latency, accept edge to `rsp_valid`: 2 cycles (3 with VERIFY on a write).
- Minimum command period: 3 cycles (IDLE, ACCESS, RESP); one more for verified writes.
- The write strobe is exactly one cycle wide per write command.
- `rsp_ready` held high: RESP lasts one cycle and `cmd_ready` rises the following cycle.
- `rsp_ready` asserted outside RESP is ignored.
- `cmd_valid` outside IDLE is ignored; the command is not consumed.
- Reset in any state returns to reset values next cycle. An in-progress write in ACCESS does not commit, because the bank shares the same reset.

## Configuration
- `REG_BANK_READBACK_EN` defined:
  - Valid-address writes go ACCESS → VERIFY.
  - VERIFY drives the same `reg_sel` with `reg_wr`=0 and compares the OR-combined read data against the latched wdata.
  - On mismatch, `rsp_err`=1 and `rsp_rdata` = the value read back; on match, `rsp_rdata`=0 and `rsp_err`=0.
- Undefined: the VERIFY state and the comparator are absent; writes go ACCESS → RESP.

## Structure
- Package `reg_bank_pkg`: FSM state enum (IDLE, ACCESS, VERIFY, RESP) and the `cmd_wr` encoding constants (CMD_RD=0, CMD_WR=1).
- Sub-module `rdata_or_reduce` (parameters WIDTH, NREGS): purely combinational OR of the NREGS slices.
- FSM and holding registers stay in the top module.

## Test plan
- Reset, then write addr 2 data 0xDEADBEEF, then read addr 2 → write response `rsp_err`=0; `reg_wr` high for exactly one cycle with `reg_sel`=4'b0100; read response `rsp_rdata`=0xDEADBEEF.
- Write 0x11, 0x22, 0x33, 0x44 to addrs 0–3, then read all four → responses 0x11, 0x22, 0x33, 0x44 in order; `reg_sel` one-hot only in ACCESS cycles.
- NREGS=3, read addr 3 → `rsp_err`=1, `rsp_rdata`=0, `reg_sel`=0 throughout, no bank register changes.
- Hold `rsp_ready`=0 for 5 cycles during RESP → `rsp_valid` and data stable, `cmd_ready`=0, extra `cmd_valid` not consumed; release → `cmd_ready`=1 the next cycle.
- Assert `reset` during ACCESS of a write of 0xA5 to addr 1 → next cycle all outputs at reset values; a subsequent read of addr 1 returns 0.
- With `REG_BANK_READBACK_EN`, force bank slice 0 to a constant 0 and write 0x5 to addr 0 → `rsp_err`=1, `rsp_rdata`=0; response arrives 3 cycles after the accept edge.
